jtopl_eg_multi: RTL and testbench



---
 rtl/jtopl_eg_multi.sv | 165 ++++++++++++++++
 tb/tb_jtopl_eg_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_eg_multi.sv
// ----------------------------------------------------------------------------
// jtopl_eg_multi : time-multiplexed ADSR envelope generator, SLOTS slots
// Optional AM is compiled in with JTOPL_EG_AM_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtopl_eg_multi #(
   parameter int SLOTS = 18,
   parameter int SW    = $clog2(SLOTS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          keyon,
   input  logic [3:0]    arate,
   input  logic [3:0]    drate,
   input  logic [3:0]    rrate,
   input  logic [3:0]    sl,
   input  logic          en_sus,
   input  logic          ks,
   input  logic [3:0]    keycode,
   input  logic [6:0]    tl,
   input  logic [6:0]    lfo_mod,
   input  logic          amsen,
   input  logic          ams,
   output logic [SW-1:0] slot,
   output logic          zero,
   output logic [9:0]    eg_out,
   output logic [1:0]    state_out,
   output logic          pg_rst
);

   localparam logic [1:0] ST_ATTACK  = 2'd0;
   localparam logic [1:0] ST_DECAY   = 2'd1;
   localparam logic [1:0] ST_SUSTAIN = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   logic [1:0]       r_state [SLOTS];
   logic [9:0]       r_eg    [SLOTS];
   logic [SLOTS-1:0] r_kon;
   logic [SW-1:0]    r_cnt;
   logic [14:0]      r_eg_cnt;

   logic        w_kon_old, w_keyon_now, w_keyoff_now;
   logic [1:0]  w_st_old, w_st_new;
   logic [9:0]  w_eg_old, w_eg_new;
   logic [4:0]  w_sl_lim;
   logic [3:0]  w_base, w_ks_add, w_r_hi, w_inc;
   logic [6:0]  w_rate_sum;
   logic [5:0]  w_rate;
   logic [11:0] w_mask;
   logic        w_step;
   logic [7:0]  w_att_k;
   logic [10:0] w_att_sub, w_dec_sum;
   logic [6:0]  w_am;
   logic [11:0] w_total;

   assign w_kon_old = r_kon[r_cnt];
   assign w_st_old  = r_state[r_cnt];
   assign w_eg_old  = r_eg[r_cnt];

`ifdef JTOPL_EG_AM_EN
   assign w_am = amsen ? (ams ? lfo_mod : (lfo_mod >> 2)) : 7'd0;
`else
   assign w_am = 7'd0;
   logic w_unused_am;
   assign w_unused_am = &{1'b0, lfo_mod, amsen, ams};
`endif

   always_comb begin
      w_keyon_now  = keyon & ~w_kon_old;
      w_keyoff_now = ~keyon & w_kon_old;
      w_sl_lim     = (sl == 4'hF) ? 5'h1F : {1'b0, sl};

      w_st_new = w_st_old;
      if (w_keyon_now)
         w_st_new = ST_ATTACK;
      else if (w_keyoff_now)
         w_st_new = ST_RELEASE;
      else if (w_st_old == ST_ATTACK && w_eg_old == 10'd0)
         w_st_new = ST_DECAY;
      else if (w_st_old == ST_DECAY && w_eg_old[9:5] >= w_sl_lim)
         w_st_new = en_sus ? ST_SUSTAIN : ST_RELEASE;

      case (w_st_new)
         ST_ATTACK: w_base = arate;
         ST_DECAY:  w_base = drate;
         ST_RELEASE: w_base = rrate;
         default:   w_base = 4'd0;
      endcase

      w_ks_add   = ks ? keycode : {2'b00, keycode[3:2]};
      w_rate_sum = {1'b0, w_base, 2'b00} + {3'b000, w_ks_add};
      if (w_base == 4'd0)
         w_rate = 6'd0;
      else if (w_rate_sum > 7'd63)
         w_rate = 6'd63;
      else
         w_rate = w_rate_sum[5:0];
      w_r_hi = w_rate[5:2];

      // Slow rates gate on the low eg_cnt bits; fast rates step every sweep with a bigger increment
      w_mask = 12'hFFF >> w_r_hi;
      if (w_r_hi < 4'd12) begin
         w_step = (r_eg_cnt[11:0] & w_mask) == 12'd0;
         w_inc  = 4'd1;
      end else begin
         w_step = 1'b1;
         w_inc  = 4'd1 << (w_r_hi - 4'd12);
      end

      w_att_k   = {1'b0, w_eg_old[9:3]} + 8'd1;
      w_att_sub = {3'b000, w_att_k} * {7'd0, w_inc};
      w_dec_sum = {1'b0, w_eg_old} + {7'd0, w_inc};

      w_eg_new = w_eg_old;
      if (w_st_new != ST_SUSTAIN && w_step) begin
         if (w_st_new == ST_ATTACK) begin
            if (w_rate >= 6'd60 || w_att_sub >= {1'b0, w_eg_old})
               w_eg_new = 10'd0;
            else
               w_eg_new = w_eg_old - w_att_sub[9:0];
         end else begin
            w_eg_new = w_dec_sum[10] ? 10'h3FF : w_dec_sum[9:0];
         end
      end

      w_total = {2'b00, w_eg_new} + {2'b00, tl, 3'b000} + {5'd0, w_am};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            r_state[i] <= ST_RELEASE;
            r_eg[i]    <= 10'h3FF;
         end
         r_kon     <= '0;
         r_cnt     <= '0;
         r_eg_cnt  <= 15'd0;
         slot      <= '0;
         zero      <= 1'b1;
         eg_out    <= 10'h3FF;
         state_out <= ST_RELEASE;
         pg_rst    <= 1'b0;
      end else if (cen) begin
         r_state[r_cnt] <= w_st_new;
         r_eg[r_cnt]    <= w_eg_new;
         r_kon[r_cnt]   <= keyon;
         slot      <= r_cnt;
         zero      <= (r_cnt == '0);
         eg_out    <= (w_total > 12'h3FF) ? 10'h3FF : w_total[9:0];
         state_out <= w_st_new;
         pg_rst    <= w_keyon_now;
         if (r_cnt == SW'(SLOTS - 1)) begin
            r_cnt    <= '0;
            r_eg_cnt <= r_eg_cnt + 15'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jtopl_eg_multi.sv
// Self-checking bench for jtopl_eg_multi: hand-computed table, directed
// corner sequences and randomized traffic against an arithmetic model.
`default_nettype none

module tb_jtopl_eg_multi;
   localparam int SLOTS = 18;
   localparam int SW    = $clog2(SLOTS);

   typedef struct {
      logic       keyon;
      logic [3:0] arate, drate, rrate, sl;
      logic       en_sus, ks;
      logic [3:0] keycode;
      logic [6:0] tl, lfo_mod;
      logic       amsen, ams;
   } ins_t;

   typedef struct {
      ins_t       in;
      logic [9:0] exp_eg;
      logic [1:0] exp_st;
      logic       exp_pg;
   } vec_t;

   logic clk = 0, rst = 0, cen = 0;
   logic keyon = 0, en_sus = 0, ks = 0, amsen = 0, ams = 0;
   logic [3:0] arate = 0, drate = 0, rrate = 0, sl = 0, keycode = 0;
   logic [6:0] tl = 0, lfo_mod = 0;
   logic [SW-1:0] slot;
   logic zero, pg_rst;
   logic [9:0] eg_out;
   logic [1:0] state_out;

   jtopl_eg_multi #(.SLOTS(SLOTS)) dut (
      .clk(clk), .rst(rst), .cen(cen), .keyon(keyon),
      .arate(arate), .drate(drate), .rrate(rrate), .sl(sl),
      .en_sus(en_sus), .ks(ks), .keycode(keycode), .tl(tl),
      .lfo_mod(lfo_mod), .amsen(amsen), .ams(ams),
      .slot(slot), .zero(zero), .eg_out(eg_out),
      .state_out(state_out), .pg_rst(pg_rst)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;

   // Reference model state
   int m_state[SLOTS], m_eg[SLOTS], m_kon[SLOTS];
   int m_slot, m_egcnt;
   int e_slot, e_zero, e_eg, e_st, e_pg;
   ins_t cfg[SLOTS];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ins_t idle();
      ins_t x;
      x.keyon = 0; x.arate = 0; x.drate = 0; x.rrate = 0; x.sl = 0;
      x.en_sus = 0; x.ks = 0; x.keycode = 0; x.tl = 0; x.lfo_mod = 0;
      x.amsen = 0; x.ams = 0;
      return x;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SLOTS; i++) begin
         m_state[i] = 3; m_eg[i] = 1023; m_kon[i] = 0;
      end
      m_slot = 0; m_egcnt = 0;
      e_slot = 0; e_zero = 1; e_eg = 1023; e_st = 3; e_pg = 0;
   endtask

   task automatic model_cen(input ins_t x);
      int s, st, eg, kn, kf, base, r, rh, inc, am, lim;
      bit step;
      s  = m_slot;
      kn = (x.keyon && !m_kon[s]) ? 1 : 0;
      kf = (!x.keyon && m_kon[s]) ? 1 : 0;
      m_kon[s] = x.keyon;
      st = m_state[s];
      eg = m_eg[s];
      lim = (x.sl == 15) ? 31 : int'(x.sl);
      if (kn != 0)                       st = 0;
      else if (kf != 0)                  st = 3;
      else if (st == 0 && eg == 0)       st = 1;
      else if (st == 1 && eg / 32 >= lim) st = x.en_sus ? 2 : 3;
      case (st)
         0: base = x.arate;
         1: base = x.drate;
         3: base = x.rrate;
         default: base = 0;
      endcase
      r  = (base == 0) ? 0 : imin(63, base * 4 + (x.ks ? int'(x.keycode) : int'(x.keycode) / 4));
      rh = r / 4;
      if (rh < 12) begin
         step = (m_egcnt % (1 << (12 - rh))) == 0;
         inc  = 1;
      end else begin
         step = 1;
         inc  = 1 << (rh - 12);
      end
      if (st != 2 && step) begin
         if (st == 0) eg = (r >= 60) ? 0 : ((eg - (eg / 8 + 1) * inc < 0) ? 0 : eg - (eg / 8 + 1) * inc);
         else         eg = imin(1023, eg + inc);
      end
      m_state[s] = st;
      m_eg[s]    = eg;
`ifdef JTOPL_EG_AM_EN
      am = x.amsen ? (x.ams ? int'(x.lfo_mod) : int'(x.lfo_mod) / 4) : 0;
`else
      am = 0;
`endif
      e_slot = s; e_zero = (s == 0) ? 1 : 0;
      e_eg = imin(1023, eg + int'(x.tl) * 8 + am);
      e_st = st; e_pg = kn;
      m_slot = (s + 1) % SLOTS;
      if (m_slot == 0) m_egcnt = (m_egcnt + 1) % 32768;
   endtask

   task automatic compare_all();
      chk("slot", int'(slot), e_slot);
      chk("zero", int'(zero), e_zero);
      chk("eg_out", int'(eg_out), e_eg);
      chk("state_out", int'(state_out), e_st);
      chk("pg_rst", int'(pg_rst), e_pg);
   endtask

   task automatic apply(input ins_t x, input bit c);
      keyon = x.keyon; arate = x.arate; drate = x.drate; rrate = x.rrate;
      sl = x.sl; en_sus = x.en_sus; ks = x.ks; keycode = x.keycode;
      tl = x.tl; lfo_mod = x.lfo_mod; amsen = x.amsen; ams = x.ams;
      cen = c;
      @(posedge clk);
      if (c) model_cen(x);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1; cen = 1;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) apply(cfg[m_slot], 1);
   endtask

   task automatic run_to(input int s);
      while (m_slot != s) apply(cfg[m_slot], 1);
      apply(cfg[m_slot], 1);
   endtask

   task automatic cfg_clear();
      for (int i = 0; i < SLOTS; i++) cfg[i] = idle();
   endtask

   vec_t tbl[6];
   ins_t v;

   initial begin
      // Expected values here are worked by hand for the first sweep (eg_cnt=0)
      v = idle(); v.keyon = 1; v.arate = 15;
      tbl[0] = '{v, 10'h000, 2'd0, 1'b1};
      v = idle();
      tbl[1] = '{v, 10'h3FF, 2'd3, 1'b0};
      v = idle(); v.keyon = 1; v.arate = 1;
      tbl[2] = '{v, 10'h37F, 2'd0, 1'b1};
      v = idle(); v.keyon = 1; v.arate = 10; v.ks = 1; v.keycode = 15; v.tl = 1;
      tbl[3] = '{v, 10'h307, 2'd0, 1'b1};
      v = idle(); v.keyon = 1; v.arate = 15; v.ks = 1; v.keycode = 15; v.tl = 7'h7F;
      tbl[4] = '{v, 10'h3F8, 2'd0, 1'b1};
      v = idle(); v.keyon = 1; v.arate = 14; v.keycode = 12; v.tl = 7'h10;
      tbl[5] = '{v, 10'h27F, 2'd0, 1'b1};

      model_reset();
      @(posedge clk); #1;
      do_reset();
      chk("reset_slot", int'(slot), 0);
      chk("reset_zero", int'(zero), 1);
      chk("reset_eg", int'(eg_out), 10'h3FF);
      chk("reset_state", int'(state_out), 3);
      chk("reset_pg", int'(pg_rst), 0);

      for (int i = 0; i < 6; i++) begin
         apply(tbl[i].in, 1);
         chk("tbl_slot", int'(slot), i);
         chk("tbl_eg", int'(eg_out), int'(tbl[i].exp_eg));
         chk("tbl_state", int'(state_out), int'(tbl[i].exp_st));
         chk("tbl_pg", int'(pg_rst), int'(tbl[i].exp_pg));
      end

      // Idle sweeps: silent, released, zero once per sweep
      do_reset();
      cfg_clear();
      begin
         int zc;
         zc = 0;
         for (int i = 0; i < 2 * SLOTS; i++) begin
            apply(cfg[m_slot], 1);
            chk("idle_slot", int'(slot), i % SLOTS);
            chk("idle_eg", int'(eg_out), 10'h3FF);
            zc += int'(zero);
         end
         chk("idle_zero_count", zc, 2);
      end

      // cen low holds everything
      for (int i = 0; i < 5; i++) begin
         v = idle(); v.keyon = 1; v.arate = 15;
         apply(v, 0);
         chk("hold_slot", int'(slot), SLOTS - 1);
      end

      // Slot 0 keyon then DECAY on next visit
      do_reset();
      cfg_clear();
      cfg[0].keyon = 1; cfg[0].arate = 15;
      run_to(0);
      chk("k0_pg", int'(pg_rst), 1);
      chk("k0_state", int'(state_out), 0);
      run_to(0);
      chk("k0_eg", int'(eg_out), 0);
      chk("k0_decay", int'(state_out), 1);
      chk("k0_pg2", int'(pg_rst), 0);

      // Slot 3 decay to sustain, then hold
      do_reset();
      cfg_clear();
      cfg[3].keyon = 1; cfg[3].arate = 15; cfg[3].drate = 15; cfg[3].sl = 4; cfg[3].en_sus = 1;
      run(SLOTS * 20);
      run_to(3);
      chk("sus_state", int'(state_out), 2);
      chk("sus_eg", int'(eg_out), 128);
      run_to(3);
      chk("sus_eg_hold", int'(eg_out), 128);

      // Same with en_sus=0: release and saturate
      do_reset();
      cfg[3].en_sus = 0; cfg[3].rrate = 15;
      run(SLOTS * 150);
      run_to(3);
      chk("rel_state", int'(state_out), 3);
      chk("rel_eg", int'(eg_out), 10'h3FF);

      // AM on top of full total level
      do_reset();
      cfg_clear();
      cfg[5].keyon = 1; cfg[5].arate = 15; cfg[5].tl = 7'h7F;
      cfg[5].amsen = 1; cfg[5].ams = 1; cfg[5].lfo_mod = 7'h7F;
      run_to(5);
`ifdef JTOPL_EG_AM_EN
      chk("am_eg", int'(eg_out), 10'h3FF);
`else
      chk("am_eg", int'(eg_out), 10'h3F8);
`endif

      // Reset in the middle of an attack
      do_reset();
      cfg_clear();
      cfg[2].keyon = 1; cfg[2].arate = 1;
      run_to(2);
      run(4);
      do_reset();
      chk("mid_rst_eg", int'(eg_out), 10'h3FF);
      chk("mid_rst_state", int'(state_out), 3);
      chk("mid_rst_slot", int'(slot), 0);
      apply(cfg[0], 1);
      chk("mid_rst_next_slot", int'(slot), 0);
      run_to(2);
      chk("mid_rst_rekey", int'(pg_rst), 1);

      // Randomized traffic against the model
      do_reset();
      cfg_clear();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            int s;
            s = $urandom_range(0, SLOTS - 1);
            cfg[s].keyon   = $urandom_range(0, 1) == 1;
            cfg[s].arate   = 4'($urandom_range(0, 15));
            cfg[s].drate   = 4'($urandom_range(0, 15));
            cfg[s].rrate   = 4'($urandom_range(0, 15));
            cfg[s].sl      = 4'($urandom_range(0, 15));
            cfg[s].en_sus  = $urandom_range(0, 1) == 1;
            cfg[s].ks      = $urandom_range(0, 1) == 1;
            cfg[s].keycode = 4'($urandom_range(0, 15));
            cfg[s].tl      = 7'($urandom_range(0, 127) & ($urandom_range(0, 1) == 1 ? 127 : 15));
            cfg[s].lfo_mod = 7'($urandom_range(0, 127));
            cfg[s].amsen   = $urandom_range(0, 1) == 1;
            cfg[s].ams     = $urandom_range(0, 1) == 1;
         end
         apply(cfg[m_slot], $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
